sram_bridge: RTL

Parametrised AVR-to-SRAM bus bridge, successor to the fixed 8-bit/21-bit bus FSM in the CPLD `system`. It loads an SRAM address serially from the AVR, runs single-clock-domain read and write cycles with programmable wait states, and optionally auto-increments the address after each access for streaming transfers. It sits between the AVR pin interface and the external SRAM pins; tristate pads are instantiated in `system`.

---
 rtl/sram_bridge_pkg.sv | 14 +
 rtl/sram_bridge_addr_sreg.sv | 32 +++
 rtl/sram_bridge.sv | 84 ++++++++
 3 files changed

// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: shared FSM encoding, wait-counter width and strobe patterns
package sram_bridge_pkg;
  localparam int WAIT_W = 4;
  typedef enum logic [2:0] {IDLE, RD_STROBE, RD_LATCH, WR_STROBE, WR_HOLD} state_t;
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } strobe_t;
  localparam strobe_t STROBE_OFF  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
  localparam strobe_t STROBE_RD   = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
  localparam strobe_t STROBE_WR   = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};
  localparam strobe_t STROBE_HOLD = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
endpackage

// File: rtl/sram_bridge_addr_sreg.sv
// addr_sreg: serial address staging register with deferred commit while an access is running
module addr_sreg
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 21
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              avr_si,
  input  logic              avr_sreg_en,
  input  logic              idle,
  input  logic              apply,
  output logic [ADDR_W-1:0] staged,
  output logic              load
);
  logic en_q, fall_q, pend;
  // a commit seen mid-access is parked until the access finishes, then wins over increment
  assign load = (fall_q & idle) | (apply & (pend | fall_q));
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      staged <= '0;
      en_q   <= 1'b0;
      fall_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (avr_sreg_en) staged <= {staged[ADDR_W-2:0], avr_si};
      en_q   <= avr_sreg_en;
      fall_q <= en_q & ~avr_sreg_en;
      pend   <= apply ? 1'b0 : pend | (fall_q & ~idle);
    end
  end
endmodule

// File: rtl/sram_bridge.sv
// sram_bridge: AVR-to-SRAM bus bridge with wait states and optional address auto-increment
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int AUTO_INC    = 1
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              avr_si,
  input  logic              avr_sreg_en,
  input  logic              avr_oe,
  input  logic              avr_we,
  input  logic [DATA_W-1:0] avr_din,
  output logic [DATA_W-1:0] avr_dout,
  output logic              avr_dout_en,
  output logic              avr_busy,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  state_t state, state_n;
  strobe_t strb;
  logic [WAIT_W-1:0] wcnt;
  logic [ADDR_W-1:0] staged;
  logic oe_q, we_q, rd_fall, wr_fall, last, rd_done, apply, load;
  assign last    = wcnt == WAIT_W'(WAIT_STATES);
  assign rd_done = state == RD_STROBE & last;
  assign apply   = rd_done | state == RD_LATCH | state == WR_HOLD;
  addr_sreg #(.ADDR_W(ADDR_W)) u_sreg (
    .avr_clk    (avr_clk),
    .avr_reset  (avr_reset),
    .avr_si     (avr_si),
    .avr_sreg_en(avr_sreg_en),
    .idle       (state == IDLE),
    .apply      (apply),
    .staged     (staged),
    .load       (load)
  );
  always_comb begin
    state_n = state == IDLE      ? (rd_fall ? RD_STROBE : wr_fall ? WR_STROBE : IDLE)
            : state == RD_STROBE ? (last ? RD_LATCH : RD_STROBE)
            : state == WR_STROBE ? (last ? WR_HOLD : WR_STROBE)
            : IDLE;
    strb = state == RD_STROBE ? STROBE_RD
         : state == WR_STROBE ? STROBE_WR
         : state == WR_HOLD   ? STROBE_HOLD
         : STROBE_OFF;
  end
  assign {sram_ce_n, sram_oe_n, sram_we_n} = strb;
  assign sram_dout_en = state == WR_STROBE | state == WR_HOLD;
  assign avr_busy     = ~sram_ce_n;
  assign avr_dout_en  = ~avr_oe & ~avr_busy;
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      rd_fall   <= 1'b0;
      wr_fall   <= 1'b0;
      sram_addr <= '0;
      avr_dout  <= '0;
      sram_dout <= '0;
    end else begin
      state   <= state_n;
      wcnt    <= state_n != state ? '0 : wcnt + 1'b1;
      oe_q    <= avr_oe;
      we_q    <= avr_we;
      rd_fall <= oe_q & ~avr_oe;
      wr_fall <= we_q & ~avr_we;
      if (state == IDLE & ~rd_fall & wr_fall) sram_dout <= avr_din;
      if (rd_done) avr_dout <= sram_din;
      if (load) sram_addr <= staged;
      else if (AUTO_INC != 0 && (rd_done | state == WR_HOLD)) sram_addr <= sram_addr + ADDR_W'(1);
    end
  end
endmodule
